pid_ctrl_gen: RTL and testbench

PID_CTRL_GEN -- requirements
Module: pid_ctrl_gen

---
 rtl/pid_pkg.sv | 34 +++
 rtl/pid_integrator.sv | 31 +++
 rtl/pid_ctrl_gen.sv | 179 +++++++++++++++++
 tb/tb_pid_ctrl_gen.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared types, thresholds and saturation helpers for the line-following PID controller.
package pid_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    RUN  = 2'd2,
    LOST = 2'd3
  } state_t;

  localparam int SPD_W  = 12;
  localparam int PID_W  = 15;
  localparam int PIDQ_W = 12;

  localparam logic [SPD_W-1:0] FRWRD_MAX = 12'h300;
  localparam logic [SPD_W-1:0] FRWRD_LOW = 12'h080;

  localparam int PID_MAX = (1 << (PID_W - 1)) - 1;
  localparam int PID_MIN = -(1 << (PID_W - 1));
  localparam int SPD_MAX = (1 << SPD_W) - 1;

  function automatic logic signed [PID_W-1:0] sat_pid(input logic signed [31:0] v);
    if (v > PID_MAX)      return PID_W'(PID_MAX);
    else if (v < PID_MIN) return PID_W'(PID_MIN);
    else                  return v[PID_W-1:0];
  endfunction

  function automatic logic [SPD_W-1:0] clamp_spd(input logic signed [SPD_W+1:0] v);
    if (v < 0)            return '0;
    else if (v > SPD_MAX) return '1;
    else                  return v[SPD_W-1:0];
  endfunction

endpackage

// File: rtl/pid_integrator.sv
// Signed error accumulator with overflow hold (anti-windup), clear and freeze.
module pid_integrator #(
  parameter int ERR_W = 11,
  parameter int ACC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    upd,
  input  logic signed [ERR_W-1:0] err,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] err_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf;

  always_comb begin
    err_ext = ACC_W'(err);
    sum     = acc + err_ext;
    // Same-sign operands producing an opposite-sign result means the add wrapped.
    ovf     = (acc[ACC_W-1] == err_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              acc <= '0;
    else if (clr)         acc <= '0;
    else if (upd && !ovf) acc <= sum;
  end

endmodule

// File: rtl/pid_ctrl_gen.sv
// Two-stage PID steering controller: stage 1 registers the error sample and state,
// stage 2 forms P+I+D and the differential wheel speeds.
module pid_ctrl_gen
  import pid_pkg::*;
#(
  parameter int ERR_W    = 11,
  parameter int ACC_W    = 16,
  parameter int D_LAG    = 2,
  parameter int RAMP_INC = 4,
  parameter int LOST_CNT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               go,
  input  logic               err_vld,
  input  logic               line_present,
  input  logic signed [15:0] error,
  input  logic [5:0]         kp,
  input  logic [6:0]         kd,
  output logic [SPD_W-1:0]   lft_spd,
  output logic [SPD_W-1:0]   rgt_spd,
  output logic               spd_vld,
  output logic [1:0]         state
);

  localparam int ERR_HI = (1 << (ERR_W - 1)) - 1;
  localparam int ERR_LO = -(1 << (ERR_W - 1));
  localparam int OFF_W  = $clog2(LOST_CNT + 1);

  state_t                  state_q, state_d;
  logic [SPD_W-1:0]        frwrd, frwrd_d;
  logic [OFF_W-1:0]        off_cnt, off_d;
  logic                    line_q, rise, lost_hit, frwrd_low;
  logic signed [ERR_W-1:0] err_sat, err_q;
  logic signed [ERR_W-1:0] hist [D_LAG];
  logic [5:0]              kp_q;
  logic [6:0]              kd_q;
  logic                    vld1;
  logic signed [ACC_W-1:0] acc;

  assign rise      = line_present && !line_q;
  assign frwrd_low = (frwrd <= FRWRD_LOW);
  assign lost_hit  = err_vld && !line_present && (off_cnt >= OFF_W'(LOST_CNT - 1));
  assign state     = state_q;

  always_comb begin
    if (int'(error) > ERR_HI)      err_sat = ERR_W'(ERR_HI);
    else if (int'(error) < ERR_LO) err_sat = ERR_W'(ERR_LO);
    else                           err_sat = error[ERR_W-1:0];
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    frwrd_d = frwrd;
    off_d   = off_cnt;
    if (err_vld) begin
      if (line_present)                     off_d = '0;
      else if (off_cnt != OFF_W'(LOST_CNT)) off_d = off_cnt + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        frwrd_d = '0;
        off_d   = '0;
        if (go) state_d = RAMP;
      end
      RAMP: begin
        if (err_vld) begin
          frwrd_d = (frwrd >= FRWRD_MAX - SPD_W'(RAMP_INC)) ? FRWRD_MAX : frwrd + SPD_W'(RAMP_INC);
          if (frwrd_d == FRWRD_MAX) state_d = RUN;
        end
        if (lost_hit) state_d = LOST;
      end
      RUN: if (lost_hit) state_d = LOST;
      LOST: begin
        if (err_vld) frwrd_d = (frwrd <= SPD_W'(RAMP_INC)) ? '0 : frwrd - SPD_W'(RAMP_INC);
        if (rise) begin
          state_d = RAMP;
          off_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!go) begin
      state_d = IDLE;
      frwrd_d = '0;
      off_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      frwrd   <= '0;
      off_cnt <= '0;
      line_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frwrd   <= frwrd_d;
      off_cnt <= off_d;
      line_q  <= line_present;
    end
  end

  pid_integrator #(.ERR_W(ERR_W), .ACC_W(ACC_W)) u_integrator (
    .clk (clk),
    .rst (rst),
    .clr ((state_q == IDLE) || rise || frwrd_low),
    .upd (err_vld && (state_q == RAMP || state_q == RUN)),
    .err (err_sat),
    .acc (acc)
  );

  // NOTE: the small history array is reset so the first derivative samples see zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
      kp_q  <= '0;
      kd_q  <= '0;
      vld1  <= 1'b0;
      for (int i = 0; i < D_LAG; i++) hist[i] <= '0;
    end else begin
      vld1 <= err_vld;
      if (err_vld) begin
        err_q   <= err_sat;
        kp_q    <= kp;
        kd_q    <= kd;
        hist[0] <= err_q;
        for (int i = 1; i < D_LAG; i++) hist[i] <= hist[i-1];
      end
    end
  end

  logic signed [ERR_W+6:0]  p_full;
  logic signed [ERR_W:0]    diff;
  logic signed [7:0]        d8;
  logic signed [15:0]       d_full;
  logic signed [PID_W-1:0]  pid_sum;
  logic signed [PIDQ_W-1:0] pid_q;
  logic [SPD_W-1:0]         lft_n, rgt_n;

  always_comb begin
    p_full = err_q * $signed({1'b0, kp_q});
    diff   = err_q - hist[D_LAG-1];
    if (diff > 127)       d8 = 8'sh7F;
    else if (diff < -128) d8 = 8'sh80;
    else                  d8 = diff[7:0];
    d_full  = d8 * $signed({1'b0, kd_q});
    // I term is the accumulator's top 10 bits, sign-extended by the arithmetic shift.
    pid_sum = sat_pid(32'(sat_pid(32'(p_full))) + 32'(acc >>> (ACC_W - 10)) + 32'(d_full));
    pid_q   = PIDQ_W'(pid_sum >>> 3);
    if (frwrd_low) begin
      lft_n = frwrd;
      rgt_n = frwrd;
    end else begin
      lft_n = clamp_spd($signed({2'b00, frwrd}) + 14'(pid_q));
      rgt_n = clamp_spd($signed({2'b00, frwrd}) - 14'(pid_q));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lft_spd <= '0;
      rgt_spd <= '0;
      spd_vld <= 1'b0;
    end else begin
      spd_vld <= vld1;
      if (state_q == IDLE) begin
        lft_spd <= '0;
        rgt_spd <= '0;
      end else if (vld1) begin
        lft_spd <= lft_n;
        rgt_spd <= rgt_n;
      end
    end
  end

endmodule

// File: tb/tb_pid_ctrl_gen.sv
// Directed bench for pid_ctrl_gen: ramp, derivative, saturation, clamp, anti-windup,
// line loss and control priority, each with hand-computed speeds.
module tb_pid_ctrl_gen;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               go = 1'b0;
  logic               err_vld = 1'b0;
  logic               line_present = 1'b0;
  logic signed [15:0] error = '0;
  logic [5:0]         kp = '0;
  logic [6:0]         kd = '0;
  logic [11:0]        lft_spd, rgt_spd;
  logic               spd_vld;
  logic [1:0]         state;

  int checks = 0;
  int passed = 0;

  pid_ctrl_gen dut (
    .clk          (clk),
    .rst          (rst),
    .go           (go),
    .err_vld      (err_vld),
    .line_present (line_present),
    .error        (error),
    .kp           (kp),
    .kd           (kd),
    .lft_spd      (lft_spd),
    .rgt_spd      (rgt_spd),
    .spd_vld      (spd_vld),
    .state        (state)
  );

  always #5 clk = ~clk;

  // n consecutive samples, then idle until stage 2 of the last one has landed.
  task automatic send(input logic signed [15:0] e, input logic l, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      error        = e;
      line_present = l;
      err_vld      = 1'b1;
    end
    @(negedge clk);
    err_vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic drop_line();
    @(negedge clk);
    line_present = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({state, spd_vld, lft_spd, rgt_spd} !== 27'd0)
      $display("FAIL reset_hold: state=%0d vld=%0b l=%0d r=%0d, want all 0", state, spd_vld, lft_spd, rgt_spd);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd0) $display("FAIL reset_idle: state=%0d want 0", state);
    else passed++;
  endtask

  task automatic test_ramp();
    logic exp_v;
    line_present = 1'b1;
    go = 1'b1;
    @(negedge clk);
    checks++;
    if (state !== 2'd1) $display("FAIL go_to_ramp: state=%0d want 1", state);
    else passed++;
    // single sample: spd_vld exactly two cycles later
    err_vld = 1'b1;
    error   = '0;
    @(negedge clk);
    err_vld = 1'b0;
    checks++;
    if (spd_vld !== 1'b0) $display("FAIL lag_c1: spd_vld=%0b want 0", spd_vld);
    else passed++;
    @(negedge clk);
    checks++;
    if ({spd_vld, lft_spd, rgt_spd} !== {1'b1, 12'd4, 12'd4})
      $display("FAIL lag_c2: vld=%0b l=%0d r=%0d want 1/4/4", spd_vld, lft_spd, rgt_spd);
    else passed++;
    @(negedge clk);
    checks++;
    if (spd_vld !== 1'b0) $display("FAIL lag_c3: spd_vld=%0b want 0", spd_vld);
    else passed++;
    // three back-to-back samples give three back-to-back spd_vld pulses
    err_vld = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp_v = (c >= 2 && c <= 4);
      checks++;
      if (spd_vld !== exp_v) $display("FAIL b2b_c%0d: spd_vld=%0b want %0b", c, spd_vld, exp_v);
      else passed++;
      if (c == 3) err_vld = 1'b0;
    end
    checks++;
    if ({lft_spd, rgt_spd} !== {12'd16, 12'd16})
      $display("FAIL ramp_16: l=%0d r=%0d want 16/16", lft_spd, rgt_spd);
    else passed++;
    send(16'sd0, 1'b1, 28);
    checks++;
    if ({state, lft_spd, rgt_spd} !== {2'd1, 12'd128, 12'd128})
      $display("FAIL ramp_128: st=%0d l=%0d r=%0d want 1/128/128", state, lft_spd, rgt_spd);
    else passed++;
    send(16'sd0, 1'b1, 1);
    checks++;
    if ({lft_spd, rgt_spd} !== {12'd132, 12'd132})
      $display("FAIL ramp_132: l=%0d r=%0d want 132/132", lft_spd, rgt_spd);
    else passed++;
    send(16'sd0, 1'b1, 158);
    checks++;
    if ({state, lft_spd, rgt_spd} !== {2'd1, 12'd764, 12'd764})
      $display("FAIL ramp_191: st=%0d l=%0d r=%0d want 1/764/764", state, lft_spd, rgt_spd);
    else passed++;
    send(16'sd0, 1'b1, 1);
    checks++;
    if ({state, lft_spd, rgt_spd} !== {2'd2, 12'd768, 12'd768})
      $display("FAIL ramp_run: st=%0d l=%0d r=%0d want 2/768/768", state, lft_spd, rgt_spd);
    else passed++;
  endtask

  task automatic test_derivative();
    kp = 6'd0;
    kd = 7'd4;
    drop_line();
    send(16'sd0, 1'b1, 1);
    send(16'sd0, 1'b1, 1);
    send(16'sd10, 1'b1, 1);
    checks++;
    if ({lft_spd, rgt_spd} !== {12'd773, 12'd763})
      $display("FAIL deriv_small: l=%0d r=%0d want 773/763", lft_spd, rgt_spd);
    else passed++;
    send(16'sd200, 1'b1, 1);
    checks++;
    if ({lft_spd, rgt_spd} !== {12'd831, 12'd705})
      $display("FAIL deriv_sat8: l=%0d r=%0d want 831/705", lft_spd, rgt_spd);
    else passed++;
  endtask

  task automatic test_saturation();
    kp = 6'd2;
    kd = 7'd0;
    drop_line();
    send(16'sh7FFF, 1'b1, 1);
    checks++;
    if ({lft_spd, rgt_spd} !== {12'd1023, 12'd513})
      $display("FAIL sat_pos: l=%0d r=%0d want 1023/513", lft_spd, rgt_spd);
    else passed++;
    drop_line();
    send(16'sh8000, 1'b1, 1);
    checks++;
    if ({lft_spd, rgt_spd} !== {12'd512, 12'd1024})
      $display("FAIL sat_neg: l=%0d r=%0d want 512/1024", lft_spd, rgt_spd);
    else passed++;
  endtask

  task automatic test_clamp();
    kp = 6'd63;
    drop_line();
    send(16'sh7FFF, 1'b1, 1);
    checks++;
    if ({lft_spd, rgt_spd} !== {12'd2815, 12'd0})
      $display("FAIL clamp_pos: l=%0d r=%0d want 2815/0", lft_spd, rgt_spd);
    else passed++;
    drop_line();
    send(16'sh8000, 1'b1, 1);
    checks++;
    if ({lft_spd, rgt_spd} !== {12'd0, 12'd2816})
      $display("FAIL clamp_neg: l=%0d r=%0d want 0/2816", lft_spd, rgt_spd);
    else passed++;
  endtask

  task automatic test_antiwindup();
    kp = 6'd0;
    drop_line();
    send(16'sd0, 1'b1, 1);
    send(16'sd1000, 1'b1, 10);
    checks++;
    if ({lft_spd, rgt_spd} !== {12'd787, 12'd749})
      $display("FAIL integ_10: l=%0d r=%0d want 787/749", lft_spd, rgt_spd);
    else passed++;
    send(16'sd1000, 1'b1, 90);
    checks++;
    if ({lft_spd, rgt_spd} !== {12'd830, 12'd706})
      $display("FAIL integ_hold: l=%0d r=%0d want 830/706", lft_spd, rgt_spd);
    else passed++;
  endtask

  task automatic test_line_loss();
    send(16'sd0, 1'b0, 7);
    checks++;
    if ({state, lft_spd, rgt_spd} !== {2'd2, 12'd830, 12'd706})
      $display("FAIL off_7: st=%0d l=%0d r=%0d want 2/830/706", state, lft_spd, rgt_spd);
    else passed++;
    send(16'sd0, 1'b0, 1);
    checks++;
    if (state !== 2'd3) $display("FAIL off_8_lost: state=%0d want 3", state);
    else passed++;
    send(16'sd0, 1'b0, 3);
    checks++;
    if ({lft_spd, rgt_spd} !== {12'd818, 12'd694})
      $display("FAIL lost_decay: l=%0d r=%0d want 818/694", lft_spd, rgt_spd);
    else passed++;
    send(16'sd0, 1'b1, 1);
    checks++;
    if ({state, lft_spd, rgt_spd} !== {2'd1, 12'd752, 12'd752})
      $display("FAIL reacquire: st=%0d l=%0d r=%0d want 1/752/752", state, lft_spd, rgt_spd);
    else passed++;
  endtask

  task automatic test_priority();
    send(16'sd0, 1'b0, 8);
    checks++;
    if (state !== 2'd3) $display("FAIL relost: state=%0d want 3", state);
    else passed++;
    @(negedge clk);
    go           = 1'b0;
    line_present = 1'b1;
    err_vld      = 1'b1;
    @(negedge clk);
    err_vld = 1'b0;
    checks++;
    if (state !== 2'd0) $display("FAIL go_over_rise: state=%0d want 0", state);
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if ({lft_spd, rgt_spd} !== 24'd0)
      $display("FAIL idle_speeds: l=%0d r=%0d want 0/0", lft_spd, rgt_spd);
    else passed++;
  endtask

  task automatic test_rst_mid_run();
    go = 1'b1;
    @(negedge clk);
    send(16'sd0, 1'b1, 192);
    checks++;
    if ({state, lft_spd, rgt_spd} !== {2'd2, 12'd768, 12'd768})
      $display("FAIL rerun: st=%0d l=%0d r=%0d want 2/768/768", state, lft_spd, rgt_spd);
    else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({state, spd_vld, lft_spd, rgt_spd} !== 27'd0)
      $display("FAIL async_rst: st=%0d vld=%0b l=%0d r=%0d want all 0", state, spd_vld, lft_spd, rgt_spd);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (state !== 2'd1) $display("FAIL post_rst_ramp: state=%0d want 1", state);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_derivative();
    test_saturation();
    test_clamp();
    test_antiwindup();
    test_line_loss();
    test_priority();
    test_rst_mid_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
